// File: rtl/bram_arb_pkg.sv
// Shared constants and request bundle for the dual-port BRAM arbiter.
// Defaults here set the parameter values of the arbiter and its interface.
package bram_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BE_WIDTH   = DEF_DATA_WIDTH / 8;

  typedef struct packed {
    logic                      we;
    logic [DEF_BE_WIDTH-1:0]   be;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } req_t;

endpackage

// File: rtl/bram_dual_arbiter_if.sv
// Requester-side bundle: per-requester valid/ready requests and read responses.
// The master side belongs to the requesters, the slave side to the arbiter.
interface bram_dual_arbiter_if
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_we;
  logic [NUM_REQ-1:0][BE_WIDTH-1:0]   req_be;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 resp_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_we, req_be,
    output req_addr, req_data,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_be,
    input  req_addr, req_data,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/bram_dual_arbiter_rr_pick2.sv
// Two-winner round-robin scan: the first valid at or after ptr wins port A,
// the next valid in the same circular order wins port B.
module rr_pick2 #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_a,
  output logic [N-1:0]  grant_b,
  output logic          found_a,
  output logic          found_b
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    grant_a = '0;
    grant_b = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N))
        sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (valid[idx]) begin
        if (!found_a) begin
          grant_a[idx] = 1'b1;
          found_a      = 1'b1;
        end else if (!found_b) begin
          grant_b[idx] = 1'b1;
          found_b      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bram_dual_arbiter.sv
// Shares one true dual-port BRAM among NUM_REQ requesters, two grants per
// cycle, with read data returned one cycle after the grant.
module bram_dual_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  bram_dual_arbiter_if.slave    bus,
  output logic [DATA_WIDTH-1:0] DI_A,
  output logic [ADDR_WIDTH-1:0] ADDR_A,
  output logic                  WE_A,
  output logic                  RE_A,
  output logic [BE_WIDTH-1:0]   BE_A,
  input  logic [DATA_WIDTH-1:0] DO_A,
  output logic [DATA_WIDTH-1:0] DI_B,
  output logic [ADDR_WIDTH-1:0] ADDR_B,
  output logic                  WE_B,
  output logic                  RE_B,
  output logic [BE_WIDTH-1:0]   BE_B,
  input  logic [DATA_WIDTH-1:0] DO_B
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      ptr, nxt_ptr, last_id;
  logic [PW-1:0]      id_a, id_b;
  logic [NUM_REQ-1:0] gnt_a, gnt_b;
  logic               fnd_a, fnd_b;
  logic               conflict, go_a, go_b;
  logic               inf_vld_a, inf_vld_b;
  logic [PW-1:0]      inf_id_a, inf_id_b;

  rr_pick2 #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .valid   (bus.req_valid),
    .ptr     (ptr),
    .grant_a (gnt_a),
    .grant_b (gnt_b),
    .found_a (fnd_a),
    .found_b (fnd_b)
  );

  always_comb begin
    id_a = '0;
    id_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_a[i]) id_a = PW'(i);
      if (gnt_b[i]) id_b = PW'(i);
    end
  end

  // A same-address pair involving a write would race inside the RAM
  assign conflict = fnd_b
                 && (bus.req_addr[id_a] == bus.req_addr[id_b])
                 && (bus.req_we[id_a] || bus.req_we[id_b]);

  assign go_a = RST_N && fnd_a;
  assign go_b = RST_N && fnd_b && !conflict;

  assign bus.req_ready = ({NUM_REQ{go_a}} & gnt_a)
                       | ({NUM_REQ{go_b}} & gnt_b);

  assign last_id = go_b ? id_b : id_a;
  assign nxt_ptr = (last_id == PW'(NUM_REQ - 1)) ? '0
                 : last_id + 1'b1;

  always_comb begin
    DI_A   = '0;
    ADDR_A = '0;
    WE_A   = 1'b0;
    RE_A   = 1'b0;
    BE_A   = '0;
    if (go_a) begin
      ADDR_A = bus.req_addr[id_a];
      WE_A   = bus.req_we[id_a];
      RE_A   = !bus.req_we[id_a];
      if (bus.req_we[id_a]) begin
        BE_A = bus.req_be[id_a];
        DI_A = bus.req_data[id_a];
      end
    end
  end

  always_comb begin
    DI_B   = '0;
    ADDR_B = '0;
    WE_B   = 1'b0;
    RE_B   = 1'b0;
    BE_B   = '0;
    if (go_b) begin
      ADDR_B = bus.req_addr[id_b];
      WE_B   = bus.req_we[id_b];
      RE_B   = !bus.req_we[id_b];
      if (bus.req_we[id_b]) begin
        BE_B = bus.req_be[id_b];
        DI_B = bus.req_data[id_b];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr       <= '0;
      inf_vld_a <= 1'b0;
      inf_vld_b <= 1'b0;
      inf_id_a  <= '0;
      inf_id_b  <= '0;
    end else begin
      inf_vld_a <= go_a && !bus.req_we[id_a];
      inf_vld_b <= go_b && !bus.req_we[id_b];
      inf_id_a  <= id_a;
      inf_id_b  <= id_b;
      if (go_a)
        ptr <= nxt_ptr;
    end
  end

  always_comb begin
    bus.resp_valid = '0;
    bus.resp_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (inf_vld_a && inf_id_a == PW'(i)) begin
        bus.resp_valid[i] = 1'b1;
        bus.resp_data[i]  = DO_A;
      end
      if (inf_vld_b && inf_id_b == PW'(i)) begin
        bus.resp_valid[i] = 1'b1;
        bus.resp_data[i]  = DO_B;
      end
    end
  end

endmodule

// File: tb/tb_bram_dual_arbiter.sv
// Bench for bram_dual_arbiter: behavioural BRAM, reference arbitration model
// with a per-requester response scoreboard, directed and random traffic.
module tb_bram_dual_arbiter;
  import bram_arb_pkg::*;

  localparam int N  = DEF_NUM_REQ;
  localparam int AW = DEF_ADDR_WIDTH;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int BW = DEF_BE_WIDTH;
  localparam int PV = DW + AW + BW + 2;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  bram_dual_arbiter_if #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)
  ) bus ();

  logic [DW-1:0] DI_A, DI_B;
  logic [DW-1:0] DO_A = '0;
  logic [DW-1:0] DO_B = '0;
  logic [AW-1:0] ADDR_A, ADDR_B;
  logic          WE_A, RE_A, WE_B, RE_B;
  logic [BW-1:0] BE_A, BE_B;

  bram_dual_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus),
    .DI_A(DI_A), .ADDR_A(ADDR_A), .WE_A(WE_A), .RE_A(RE_A),
    .BE_A(BE_A), .DO_A(DO_A),
    .DI_B(DI_B), .ADDR_B(ADDR_B), .WE_B(WE_B), .RE_B(RE_B),
    .BE_B(BE_B), .DO_B(DO_B)
  );

  // Synchronous read-first dual-port RAM with byte enables
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (RE_A) DO_A <= mem[ADDR_A];
    if (RE_B) DO_B <= mem[ADDR_B];
    for (int b = 0; b < BW; b++) begin
      if (WE_A && BE_A[b]) mem[ADDR_A][8*b +: 8] = DI_A[8*b +: 8];
      if (WE_B && BE_B[b]) mem[ADDR_B][8*b +: 8] = DI_B[8*b +: 8];
    end
  end

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  exp_t          expq [N][$];
  logic [DW-1:0] last_resp [N];
  int            waitc [N];
  int            ptr_m = 0;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic req_t mk(logic we, logic [BW-1:0] be,
                              logic [AW-1:0] addr, logic [DW-1:0] data);
    req_t r;
    r.we = we; r.be = be; r.addr = addr; r.data = data;
    return r;
  endfunction

  function automatic logic [PV-1:0] port_exp(int g);
    logic [PV-1:0] v;
    v = '0;
    if (g >= 0) begin
      if (bus.req_we[g])
        v = {2'b10, bus.req_addr[g], bus.req_be[g], bus.req_data[g]};
      else
        v = {2'b01, bus.req_addr[g], {BW{1'b0}}, {DW{1'b0}}};
    end
    return v;
  endfunction

  function automatic void apply_write(int g);
    for (int b = 0; b < BW; b++)
      if (bus.req_be[g][b])
        ref_mem[bus.req_addr[g]][8*b +: 8] = bus.req_data[g][8*b +: 8];
  endfunction

  // Reference arbitration: circular scan from ptr_m, two winners, conflict rule
  always @(negedge CLK) begin : model
    int            order [$];
    int            a, b;
    logic [N-1:0]  er;
    logic [PV-1:0] pa, pb;
    pa = {WE_A, RE_A, ADDR_A, BE_A, DI_A};
    pb = {WE_B, RE_B, ADDR_B, BE_B, DI_B};
    if (!RST_N) begin
      total++;
      if (bus.req_ready !== '0) begin
        bad++;
        $display("FAIL ready_in_reset got=%b want=0", bus.req_ready);
      end
      total++;
      if (pa !== '0 || pb !== '0) begin
        bad++;
        $display("FAIL ports_in_reset got=%h/%h want=0", pa, pb);
      end
    end else begin
      order.delete();
      for (int k = 0; k < N; k++)
        if (bus.req_valid[(ptr_m + k) % N]) order.push_back((ptr_m + k) % N);
      er = '0; a = -1; b = -1;
      if (order.size() > 0) begin a = order[0]; er[a] = 1'b1; end
      if (order.size() > 1) begin
        b = order[1];
        if (bus.req_addr[a] == bus.req_addr[b] && (bus.req_we[a] || bus.req_we[b]))
          b = -1;
        else
          er[b] = 1'b1;
      end
      total++;
      if (bus.req_ready !== er) begin
        bad++;
        $display("FAIL ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, er);
      end
      total++;
      if (pa !== port_exp(a)) begin
        bad++;
        $display("FAIL port_a cyc=%0d got=%h want=%h", cyc, pa, port_exp(a));
      end
      total++;
      if (pb !== port_exp(b)) begin
        bad++;
        $display("FAIL port_b cyc=%0d got=%h want=%h", cyc, pb, port_exp(b));
      end
      if (a >= 0 && !bus.req_we[a]) expq[a].push_back('{cyc + 1, ref_mem[bus.req_addr[a]]});
      if (b >= 0 && !bus.req_we[b]) expq[b].push_back('{cyc + 1, ref_mem[bus.req_addr[b]]});
      if (a >= 0 && bus.req_we[a]) apply_write(a);
      if (b >= 0 && bus.req_we[b]) apply_write(b);
      if (b >= 0) ptr_m = (b + 1) % N;
      else if (a >= 0) ptr_m = (a + 1) % N;
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && er[i]) begin
          total++;
          if (waitc[i] >= N) begin
            bad++;
            $display("FAIL starve id=%0d got=%0d want<%0d", i, waitc[i], N);
          end
          waitc[i] = 0;
        end else if (bus.req_valid[i]) begin
          waitc[i]++;
        end else begin
          waitc[i] = 0;
        end
      end
    end
  end

  always @(negedge CLK) begin : monitor
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (bus.resp_valid[i]) begin
        total++;
        last_resp[i] = bus.resp_data[i];
        if (!RST_N) begin
          bad++;
          $display("FAIL resp_in_reset id=%0d got=1 want=0", i);
        end else if (expq[i].size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected id=%0d got=%h want=none", i, bus.resp_data[i]);
        end else begin
          e = expq[i].pop_front();
          if (e.cyc != cyc || e.data !== bus.resp_data[i]) begin
            bad++;
            $display("FAIL resp id=%0d got=%h@%0d want=%h@%0d",
                     i, bus.resp_data[i], cyc, e.data, e.cyc);
          end
        end
      end else if (expq[i].size() > 0 && expq[i][0].cyc <= cyc) begin
        total++;
        bad++;
        $display("FAIL resp_missing id=%0d got=none want=%h", i, expq[i][0].data);
        void'(expq[i].pop_front());
      end
    end
  end

  task automatic set_req(input int i, input req_t r);
    bus.req_valid[i] = 1'b1;
    bus.req_we[i]    = r.we;
    bus.req_be[i]    = r.be;
    bus.req_addr[i]  = r.addr;
    bus.req_data[i]  = r.data;
  endtask

  task automatic step(output logic [N-1:0] f);
    @(negedge CLK);
    f = bus.req_valid & bus.req_ready;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int max);
    logic [N-1:0] f;
    int n;
    n = 0;
    while (bus.req_valid != '0 && n < max) begin
      step(f);
      bus.req_valid = bus.req_valid & ~f;
      n++;
    end
    total++;
    if (bus.req_valid != '0) begin
      bad++;
      $display("FAIL drain_timeout got=%b want=0", bus.req_valid);
      bus.req_valid = '0;
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < N; i++) begin
      expq[i].delete();
      waitc[i] = 0;
    end
    ptr_m = 0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    flush_model();
    bus.req_valid = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin : stim
    logic [N-1:0] f;
    logic [DW-1:0] v;
    f = '0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_be    = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < N; i++) begin
      waitc[i] = 0;
      last_resp[i] = '0;
    end
    for (int k = 0; k < (1 << AW); k++) begin
      v = $urandom;
      mem[k] = v;
      ref_mem[k] = v;
    end
    mem[3] = 32'h11223344;
    ref_mem[3] = 32'h11223344;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Single read from requester 0
    set_req(0, mk(1'b0, '0, 10'd5, '0));
    drain(8);
    idle(2);

    // All four reading continuously from ptr=0
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, mk(1'b0, '0, AW'(10 + i), '0));
    repeat (6) step(f);
    bus.req_valid = '0;
    idle(2);

    // Write/read conflict on address 7
    do_reset();
    set_req(0, mk(1'b1, 4'hF, 10'd7, 32'hCAFEF00D));
    set_req(1, mk(1'b0, '0, 10'd7, '0));
    drain(8);
    idle(2);

    // Byte-enabled write followed by read-back
    set_req(2, mk(1'b1, 4'b0101, 10'd3, 32'hAABBCCDD));
    step(f);
    bus.req_valid = bus.req_valid & ~f;
    total++;
    if (f[2] !== 1'b1) begin
      bad++;
      $display("FAIL be_write_grant got=%b want=1", f[2]);
    end
    set_req(2, mk(1'b0, '0, 10'd3, '0));
    drain(8);
    idle(2);
    total++;
    if (last_resp[2] !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL be_readback got=%h want=11bb33dd", last_resp[2]);
    end

    // Reset lands right after reads from 1 and 3 are granted
    do_reset();
    set_req(1, mk(1'b0, '0, 10'd20, '0));
    set_req(3, mk(1'b0, '0, 10'd21, '0));
    @(negedge CLK);
    #1;
    RST_N = 1'b0;
    flush_model();
    bus.req_valid[3] = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    drain(8);
    idle(2);

    // Random traffic: mixed load, then every requester always valid
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || f[i]) begin
          set_req(i, mk($urandom_range(0, 2) == 0, BW'($urandom),
                        AW'($urandom_range(0, 7)), $urandom));
          if (c < 200)
            bus.req_valid[i] = ($urandom_range(0, 3) != 0);
        end
      end
      step(f);
    end
    bus.req_valid = '0;
    idle(4);

    for (int i = 0; i < N; i++) begin
      total++;
      if (expq[i].size() != 0) begin
        bad++;
        $display("FAIL leftover id=%0d got=%0d want=0", i, expq[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_dual_arbiter.md
BRAM_DUAL_ARBITER -- requirements
Module: bram_dual_arbiter

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-003 Parameter ADDR_WIDTH, default 10: RAM address width.
REQ-004 Parameter DATA_WIDTH, default 32: RAM data width, a multiple of 8.
REQ-005 Parameter BE_WIDTH, default DATA_WIDTH/8: byte-enable width.
REQ-006 CLK  in  1  clock; all state updates on the rising edge.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  NUM_REQ  per-requester request present.
REQ-009 req_ready  out  NUM_REQ  per-requester grant; transfer when valid&ready.
REQ-010 req_we / req_be / req_addr / req_data  in  NUM_REQ x (1/BE_WIDTH/ADDR_WIDTH/DATA_WIDTH)  per-requester write flag, byte enables, address, write data.
REQ-011 resp_valid  out  NUM_REQ  read data valid for that requester, one-cycle pulse, no backpressure.
REQ-012 resp_data  out  NUM_REQ x DATA_WIDTH  read data per requester.
REQ-013 DI_A, ADDR_A, WE_A, RE_A, BE_A  out  (DATA_WIDTH, ADDR_WIDTH, 1, 1, BE_WIDTH)  RAM port A drive; DO_A  in  DATA_WIDTH.
REQ-014 DI_B, ADDR_B, WE_B, RE_B, BE_B, DO_B: same as port A, for port B.

Function
REQ-015 Per cycle, grant at most two requests: scan req_valid in round-robin order from pointer ptr; first valid goes to port A, second to port B.
REQ-016 Port B grant SHALL be suppressed if its address equals the port A address and either request is a write; that requester stays unready.
REQ-017 req_ready SHALL be combinational from req_valid, ptr and the conflict check; ready SHALL never assert without valid.
REQ-018 Granted write: WE=1, RE=0, BE/DI/ADDR from the requester; no response is generated.
REQ-019 Granted read: RE=1, WE=0, BE=0, DI=0; resp_valid[id] SHALL pulse exactly one cycle after the grant cycle with resp_data[id] = DO of the granting port.
REQ-020 Idle port: WE=0, RE=0, ADDR/DI/BE=0.
REQ-021 ptr update: next ptr = (last granted id + 1) mod NUM_REQ; no grant leaves ptr unchanged.
REQ-022 Two reads to the same address in one cycle SHALL both be granted, both responses in the same cycle.
REQ-023 Write at cycle t then read of the same address at t+1 SHALL return the written bytes; bytes with BE=0 keep their old value.
REQ-024 A requester holding valid SHALL be granted within NUM_REQ cycles (starvation-free).
REQ-025 resp_data for a requester with resp_valid=0 is don't-care but SHALL NOT be X after reset.

Reset
REQ-026 On RST_N low: ptr=0, per-port in-flight id/valid registers=0, resp_valid=0, resp_data=0.
REQ-027 Reads granted in the cycle reset asserts SHALL produce no response; writes in flight complete or not (undefined RAM content).
REQ-028 req_ready SHALL be 0 while RST_N is low.

Structure
REQ-029 Package bram_arb_pkg SHALL hold the default parameter constants and the typedef for a request struct {we, be, addr, data}.
REQ-030 One sub-module rr_pick2 SHALL implement the two-winner round-robin scan (inputs valid vector and ptr; outputs two one-hot grants plus found flags).
REQ-031 In-flight state SHALL be two registers (valid, id) per port; no other storage.

Verification
REQ-032 Reset, then req 0 read addr 5 -> cycle t: RE_A=1 ADDR_A=5; t+1: resp_valid=4'b0001, resp_data[0]=RAM[5].
REQ-033 All four requesters read continuously from ptr=0 -> grants {0,1},{2,3},{0,1}; ptr 0->2->0.
REQ-034 Req 0 writes addr 7, req 1 reads addr 7 same cycle -> only req 0 ready; req 1 granted next cycle, returns new data.
REQ-035 Req 2 writes 0xAABBCCDD BE=4'b0101 to addr 3 (old 0x11223344), req 2 reads addr 3 next cycle -> 0x11BB33DD.
REQ-036 Reads from req 1 and 3 granted, RST_N low at next edge -> resp_valid stays 0, ptr=0.
REQ-037 Random traffic, all NUM_REQ valid -> every requester granted within 4 cycles; scoreboard matches RAM model.
